rr_arbiter_8: RTL and testbench
===============================

// Module: rr_arbiter_8
// PURPOSE
//   Round-robin arbiter that shares one resource between 8 requesters.
//   - Scans a rotated request vector with a priority-encode stage and issues a registered one-hot grant plus binary grant ID.
//   - Holds the grant until the owner signals done, drops its request, or exceeds a hold limit.
//   - Sits in front of any shared datapath, e.g. a bus port or a memory port; the downstream mux is steered by gnt_id.
// PARAMETERS
//   NUM_REQ   8    number of requesters; fixed at 8 in this revision
//   ID_W      3    width of gnt_id, log2(NUM_REQ)
//   MAX_HOLD  16   max cycles one grant may be held before forced release; legal range 2..255
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high
//   req        in   8      request lines; bit i = requester i
//   done       in   1      owner finished; qualified only while gnt_valid=1
//   gnt        out  8      one-hot grant; all-zero when idle
//   gnt_id     out  3      binary index of granted requester; 0 when idle
//   gnt_valid  out  1      a grant is active
//   timeout    out  1      1-cycle pulse on a forced release at MAX_HOLD
// BEHAVIOUR
//   Reset
//   - One clock, synchronous active-high reset.
//   - rst=1 at a rising edge clears everything on that edge, including mid-grant:
//     gnt=0, gnt_id=0, gnt_valid=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE.
//   - A grant in progress is dropped with no timeout pulse.
//   - All outputs are registered.
//   State machine
//   - IDLE
//     - If req!=0, select the winner and go to GRANT.
//     - Outputs become valid on the next edge, so req->gnt latency is 1 cycle.
//   - GRANT
//     - gnt, gnt_id and winner are frozen; hold_cnt increments each cycle.
//     - Release on any of three conditions:
//       a) done=1
//       b) req[gnt_id]=0
//       c) hold_cnt==MAX_HOLD-1 with no done and req still high; this also pulses timeout=1 for one cycle.
//     - On release: ptr <= gnt_id+1 mod 8, hold_cnt <= 0, outputs cleared, go to RELEASE.
//     - The GRANT period is exactly MAX_HOLD cycles when forced.
//   - RELEASE
//     - One dead cycle with gnt_valid=0 so the shared datapath can settle; then IDLE.
//     - Requests seen during RELEASE are not granted until the IDLE cycle that follows.
//     - Minimum back-to-back spacing between grants is therefore 2 idle-output cycles.
//   Winner selection
//   - rot = req rotated right by ptr.
//   - The lowest set bit k of rot wins; winner = (ptr+k) mod 8 (wrap-around from index 7 to 0).
//   - With ptr=0, index 0 is highest priority.
//   - A single requester is always granted, regardless of ptr.
//   Simultaneous events
//   - done and the hold limit in the same cycle: normal release, timeout=0.
//   - A new req rising on the owner's own line during GRANT has no effect.
//   - done while gnt_valid=0 is ignored.
//   Invariants
//   - gnt == (gnt_valid ? 1<<gnt_id : 0).
//   - At most one bit of gnt is set.
//   - timeout=1 implies gnt_valid=0 in the same cycle.
// TESTING
//   1. Reset then single requester: rst 2 cycles, req=8'h04 -> gnt=8'h04, gnt_id=2, gnt_valid=1 one cycle after req; done=1 -> gnt=0 next cycle.
//   2. Rotation with all requesting: req=8'hFF, pulse done after each grant -> grant order 0,1,2,...,7,0.
//      - Each grant is separated by exactly 2 cycles of gnt_valid=0.
//   3. Timeout: req=8'h01 held, done never asserted (MAX_HOLD=16) -> gnt_valid=1 for exactly 16 cycles.
//      - Then gnt=0 and a 1-cycle timeout pulse; next winner is 0 again after RELEASE+IDLE.
//   4. Wrap and fairness: ptr=7 (after granting 6), req=8'h41 -> winner 0 (wrap); done -> next winner 6.
//   5. Request drop and mid-grant reset:
//      - Owner 3 drops req[3] while granted -> release next edge, no timeout.
//      - Re-grant, then assert rst mid-GRANT -> all outputs 0 next edge; subsequent req=8'h88 grants 3 (ptr=0).
//   6. Simultaneous done and hold limit at cycle MAX_HOLD-1 -> release with timeout=0; done while idle -> no output change.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// ============================================================================
// Module   : rr_arbiter_8
// Purpose  : 8-way round-robin arbiter with registered one-hot grant, binary
//            grant ID, owner hold limit and one dead cycle between grants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_8 #(
    parameter int NUM_REQ  = 8,
    parameter int ID_W     = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                done,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_W-1:0]     gnt_id,
    output logic                gnt_valid,
    output logic                timeout
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_GRANT   = 2'd1;
    localparam logic [1:0] S_RELEASE = 2'd2;

    localparam logic [7:0] c_HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     w_ptr_nxt;
    logic [7:0]          r_hold_cnt;
    logic [7:0]          w_hold_nxt;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  w_gnt_nxt;
    logic [ID_W-1:0]     r_gnt_id;
    logic [ID_W-1:0]     w_gnt_id_nxt;
    logic                r_gnt_valid;
    logic                w_gnt_valid_nxt;
    logic                r_timeout;
    logic                w_timeout_nxt;

    logic [NUM_REQ-1:0]  w_rot;
    logic [ID_W-1:0]     w_off;
    logic [ID_W-1:0]     w_winner;
    logic                w_any;
    logic                w_owner_req;
    logic                w_hold_last;
    logic                w_release;
    logic                w_force;

    // Rotate so that requester r_ptr lands at bit 0, then pick the lowest set bit.
    always_comb begin
        w_rot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_rot[i] = req[r_ptr + ID_W'(i)];
        end
    end

    always_comb begin
        w_off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = ID_W'(k);
            end
        end
    end

    assign w_any       = |req;
    assign w_winner    = r_ptr + w_off;
    assign w_owner_req = req[r_gnt_id];
    assign w_hold_last = (r_hold_cnt == c_HOLD_LAST);
    assign w_release   = done | ~w_owner_req | w_hold_last;
    // A forced release only counts when nothing else already ended the grant.
    assign w_force     = w_hold_last & ~done & w_owner_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_hold_cnt  <= '0;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_timeout   <= w_timeout_nxt;
        end
    end

    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE:    w_state_nxt = w_any ? S_GRANT : S_IDLE;
            S_GRANT:   w_state_nxt = w_release ? S_RELEASE : S_GRANT;
            S_RELEASE: w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ptr_nxt       = r_ptr;
        w_hold_nxt      = r_hold_cnt;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_gnt_valid_nxt = r_gnt_valid;
        w_timeout_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_gnt_nxt           = '0;
                    w_gnt_nxt[w_winner] = 1'b1;
                    w_gnt_id_nxt        = w_winner;
                    w_gnt_valid_nxt     = 1'b1;
                    w_hold_nxt          = '0;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_ptr_nxt       = r_gnt_id + ID_W'(1);
                    w_hold_nxt      = '0;
                    w_gnt_nxt       = '0;
                    w_gnt_id_nxt    = '0;
                    w_gnt_valid_nxt = 1'b0;
                    w_timeout_nxt   = w_force;
                end else begin
                    w_hold_nxt = r_hold_cnt + 8'd1;
                end
            end
            default: begin
                w_gnt_nxt       = '0;
                w_gnt_id_nxt    = '0;
                w_gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign gnt_valid = r_gnt_valid;
    assign timeout   = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
// ============================================================================
// Module   : tb_rr_arbiter_8
// Purpose  : Self-checking bench for rr_arbiter_8: directed scenarios plus
//            randomized traffic against a cycle-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic       done = 1'b0;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: owner index (-1 when nobody owns the resource),
    // cycles owned so far, dead cycles left before arbitration resumes.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_held  = 0;
    int m_cool  = 0;
    bit m_tmo   = 1'b0;

    rr_arbiter_8 #(.NUM_REQ(8), .ID_W(3), .MAX_HOLD(MAX_HOLD)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_edge(input logic [7:0] r, input logic d, input logic rs);
        m_tmo = 1'b0;
        if (rs) begin
            m_owner = -1; m_ptr = 0; m_held = 0; m_cool = 0;
        end else if (m_owner >= 0) begin
            m_held++;
            if (d || !r[m_owner]) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1; m_cool = 1;
            end else if (m_held == MAX_HOLD) begin
                m_ptr = (m_owner + 1) % 8; m_owner = -1; m_cool = 1; m_tmo = 1'b1;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else if (r != 8'h00) begin
            for (int i = 7; i >= 0; i--) begin
                if (r[(m_ptr + i) % 8]) m_owner = (m_ptr + i) % 8;
            end
            m_held = 0;
        end
    endtask

    task automatic step(input logic [7:0] r, input logic d, input logic rs);
        logic [7:0] e_gnt;
        req = r; done = d; rst = rs;
        @(posedge clk);
        model_edge(r, d, rs);
        #1;
        e_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
        check_eq("gnt",       32'(gnt),       32'(e_gnt));
        check_eq("gnt_id",    32'(gnt_id),    (m_owner >= 0) ? 32'(m_owner) : 32'd0);
        check_eq("gnt_valid", 32'(gnt_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        check_eq("timeout",   32'(timeout),   32'(m_tmo));
    endtask

    initial begin
        int vcnt;
        int tcnt;
        logic [7:0] r;

        // Test 1: reset then a single requester
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        check_eq("reset_gnt", 32'(gnt), 32'h0);
        step(8'h04, 1'b0, 1'b0);
        check_eq("t1_gnt", 32'(gnt), 32'h04);
        check_eq("t1_id",  32'(gnt_id), 32'd2);
        step(8'h04, 1'b1, 1'b0);
        check_eq("t1_rel", 32'(gnt), 32'h00);

        // Test 2: full rotation with everyone requesting
        step(8'h00, 1'b0, 1'b1);
        step(8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            check_eq("t2_order", 32'(gnt_id), 32'(i % 8));
            step(8'hFF, 1'b1, 1'b0);
            step(8'hFF, 1'b0, 1'b0);
            step(8'hFF, 1'b0, 1'b0);
        end

        // Test 3: hold limit forces release
        step(8'h00, 1'b0, 1'b1);
        vcnt = 0; tcnt = 0;
        for (int i = 0; i < 18; i++) begin
            step(8'h01, 1'b0, 1'b0);
            vcnt += int'(gnt_valid);
            tcnt += int'(timeout);
        end
        check_eq("t3_valid_cycles", 32'(vcnt), 32'd16);
        check_eq("t3_timeouts", 32'(tcnt), 32'd1);
        step(8'h01, 1'b0, 1'b0);
        check_eq("t3_regrant", 32'(gnt), 32'h01);

        // Test 4: wrap-around from pointer 7
        step(8'h00, 1'b0, 1'b1);
        step(8'h40, 1'b0, 1'b0);
        step(8'h40, 1'b1, 1'b0);
        step(8'h41, 1'b0, 1'b0);
        step(8'h41, 1'b0, 1'b0);
        check_eq("t4_wrap", 32'(gnt_id), 32'd0);
        step(8'h41, 1'b1, 1'b0);
        step(8'h41, 1'b0, 1'b0);
        step(8'h41, 1'b0, 1'b0);
        check_eq("t4_fair", 32'(gnt_id), 32'd6);

        // Test 5: request drop, then reset in the middle of a grant
        step(8'h00, 1'b0, 1'b1);
        step(8'h08, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
        check_eq("t5_drop_tmo", 32'(timeout), 32'd0);
        step(8'h08, 1'b0, 1'b0);
        step(8'h08, 1'b0, 1'b0);
        step(8'h08, 1'b0, 1'b0);
        step(8'h08, 1'b0, 1'b1);
        check_eq("t5_rst_valid", 32'(gnt_valid), 32'd0);
        step(8'h88, 1'b0, 1'b0);
        check_eq("t5_after_rst", 32'(gnt_id), 32'd3);

        // Test 6: done coincides with the hold limit, then done while idle
        step(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < MAX_HOLD; i++) step(8'h01, 1'b0, 1'b0);
        step(8'h01, 1'b1, 1'b0);
        check_eq("t6_no_tmo", 32'(timeout), 32'd0);
        for (int i = 0; i < 3; i++) step(8'h00, 1'b1, 1'b0);
        check_eq("t6_idle_done", 32'(gnt_valid), 32'd0);

        // Randomized traffic
        step(8'h00, 1'b0, 1'b1);
        r = 8'h00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 3) begin
                r = 8'($urandom);
                if ($urandom_range(0, 3) == 0) r = r & (8'h01 << $urandom_range(0, 7));
            end
            step(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
